ble_rx_dma: RTL and testbench

- Sits between the BLE uart_rx stage and servant_ram.
- Buffers received bytes in a small FIFO and writes them into a RAM window (ADR_LL..ADR_UL-1) over Wishbone, one byte per transaction.
- Arbitrates the single RAM port with the servant CPU bus, replacing ad-hoc muxing in the top level.

---
 rtl/ble_rx_dma.sv | 157 +++++++++++++++
 tb/tb_ble_rx_dma.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ble_rx_dma.sv
// RX byte FIFO + DMA writer into a RAM window, sharing the RAM Wishbone port with the CPU.
// Optional RX_DMA_STATUS_EN: local status word at ADR_UL (overflow, FIFO count, wr_ptr).
module ble_rx_dma #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] ADR_LL     = 32'h00C00000,
  parameter logic [31:0] ADR_UL     = 32'h00C10000
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  input  logic        i_cpu_we,
  input  logic [3:0]  i_cpu_sel,
  input  logic [31:0] i_cpu_dat,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic [31:0] o_ram_adr,
  output logic        o_ram_cyc,
  output logic        o_ram_we,
  output logic [3:0]  o_ram_sel,
  output logic [31:0] o_ram_dat,
  input  logic [31:0] i_ram_rdt,
  input  logic        i_ram_ack,
  output logic [31:0] o_wr_ptr,
  output logic        o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, CPU, DMA} state_t;

  state_t          state;
  logic            last_cpu;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   wr_idx;
  logic [CW-1:0]   count;
  logic [31:0]     wr_ptr;
  logic            overflow;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            status_hit;
  logic            status_clr;
  logic            cpu_done;
  logic [31:0]     next_ptr;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = (state == DMA) && i_ram_ack;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = i_rx_done && (!full || pop);
  assign next_ptr = wr_ptr + 32'd1;

`ifdef RX_DMA_STATUS_EN
  assign status_hit = (state == CPU) && (i_cpu_adr == ADR_UL);
  assign status_clr = status_hit && i_cpu_we && i_cpu_sel[3] && i_cpu_dat[31];
`else
  assign status_hit = 1'b0;
  assign status_clr = 1'b0;
`endif

  assign cpu_done   = status_hit || i_ram_ack;
  assign o_wr_ptr   = wr_ptr;
  assign o_overflow = overflow;

  always_ff @(posedge i_wb_clk) begin
    if (push) mem[wr_idx] <= i_rx_data;
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state    <= IDLE;
      last_cpu <= 1'b0;
      rd_idx   <= '0;
      wr_idx   <= '0;
      count    <= '0;
      wr_ptr   <= ADR_LL;
      overflow <= 1'b0;
    end else begin
      if (push) wr_idx <= wr_idx + AW'(1);
      if (pop)  rd_idx <= rd_idx + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (i_rx_done && full && !pop) overflow <= 1'b1;
      else if (status_clr)           overflow <= 1'b0;

      case (state)
        IDLE: begin
          // On contention, serve whoever did not win last time.
          if (i_cpu_cyc && !empty) begin
            state    <= last_cpu ? DMA : CPU;
            last_cpu <= !last_cpu;
          end else if (i_cpu_cyc) begin
            state    <= CPU;
            last_cpu <= 1'b1;
          end else if (!empty) begin
            state    <= DMA;
            last_cpu <= 1'b0;
          end
        end
        CPU: begin
          if (cpu_done) state <= IDLE;
        end
        DMA: begin
          if (i_ram_ack) begin
            wr_ptr <= (next_ptr == ADR_UL) ? ADR_LL : next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ram_adr = '0;
    o_ram_cyc = 1'b0;
    o_ram_we  = 1'b0;
    o_ram_sel = '0;
    o_ram_dat = '0;
    o_cpu_ack = 1'b0;
    o_cpu_rdt = i_ram_rdt;
    case (state)
      CPU: begin
        if (status_hit) begin
          o_cpu_ack = 1'b1;
          o_cpu_rdt = {overflow, 7'(count), wr_ptr[23:0]};
        end else begin
          o_ram_adr = i_cpu_adr;
          o_ram_cyc = i_cpu_cyc;
          o_ram_we  = i_cpu_we;
          o_ram_sel = i_cpu_sel;
          o_ram_dat = i_cpu_dat;
          o_cpu_ack = i_ram_ack;
        end
      end
      DMA: begin
        o_ram_adr = {wr_ptr[31:2], 2'b00};
        o_ram_cyc = 1'b1;
        o_ram_we  = 1'b1;
        o_ram_sel = 4'b0001 << wr_ptr[1:0];
        o_ram_dat = {4{mem[rd_idx]}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ble_rx_dma.sv
// Directed bench for ble_rx_dma with a small RAM window (ADR_UL = ADR_LL + 8) and a one-wait-state RAM.
module tb_ble_rx_dma;

  localparam logic [31:0] LL = 32'h00C00000;
  localparam logic [31:0] UL = 32'h00C00008;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic [31:0] cpu_adr = '0;
  logic        cpu_cyc = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_dat = '0;
  logic [31:0] cpu_rdt;
  logic        cpu_ack;
  logic [31:0] ram_adr;
  logic        ram_cyc;
  logic        ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_dat;
  logic [31:0] ram_rdt;
  logic        ram_ack;
  logic [31:0] wr_ptr;
  logic        overflow;
  logic        stall = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        log_we  [$];
  logic [31:0] log_adr [$];
  logic [3:0]  log_sel [$];
  logic [31:0] log_dat [$];
  logic        ram_cyc_seen = 1'b0;
  logic [31:0] last_rdt = '0;

  ble_rx_dma #(.FIFO_DEPTH(16), .ADR_LL(LL), .ADR_UL(UL)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst),
    .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_cpu_adr(cpu_adr), .i_cpu_cyc(cpu_cyc), .i_cpu_we(cpu_we),
    .i_cpu_sel(cpu_sel), .i_cpu_dat(cpu_dat),
    .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
    .o_ram_adr(ram_adr), .o_ram_cyc(ram_cyc), .o_ram_we(ram_we),
    .o_ram_sel(ram_sel), .o_ram_dat(ram_dat),
    .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack),
    .o_wr_ptr(wr_ptr), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  // RAM answers one cycle after cyc, unless stalled; read data is a fixed function of address.
  always @(posedge clk) begin
    if (rst) ram_ack <= 1'b0;
    else     ram_ack <= ram_cyc && !ram_ack && !stall;
  end
  assign ram_rdt = ram_adr ^ 32'h5A5A0000;

  always @(negedge clk) begin
    if (ram_cyc && ram_ack) begin
      log_we.push_back(ram_we);
      log_adr.push_back(ram_adr);
      log_sel.push_back(ram_sel);
      log_dat.push_back(ram_dat);
    end
    if (ram_cyc) ram_cyc_seen = 1'b1;
    if (cpu_ack) last_rdt = cpu_rdt;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk); #1 rx_done = 1'b1; rx_data = b;
    @(negedge clk); #1 rx_done = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clearLogs();
    log_we.delete(); log_adr.delete(); log_sel.delete(); log_dat.delete();
    ram_cyc_seen = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk); #1 rst = 1'b1; stall = 1'b0; cpu_cyc = 1'b0; rx_done = 1'b0;
    @(negedge clk); #1 rst = 1'b0;
    clearLogs();
  endtask

  task automatic waitCpuAck(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 100);
    checkOutput(tag, {31'b0, cpu_ack}, 32'd1);
    #1 cpu_cyc = 1'b0;
  endtask

  logic [31:0] exp_adr [5] = '{32'h00C00000, 32'h00C00000, 32'h00C00000, 32'h00C00000, 32'h00C00004};
  logic [3:0]  exp_sel [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [31:0] exp_dat [5] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};

  initial begin
    int n;
    waitCycles(3);
    checkOutput("rst_ram_cyc", {31'b0, ram_cyc}, 32'd0);
    checkOutput("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    checkOutput("rst_ram_adr", ram_adr, 32'd0);
    checkOutput("rst_ram_sel", {28'b0, ram_sel}, 32'd0);
    checkOutput("rst_wr_ptr", wr_ptr, LL);
    checkOutput("rst_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b0;
    clearLogs();

    // Single byte.
    applyStimulus(8'hA5);
    waitCycles(10);
    checkOutput("t1_count", log_adr.size(), 32'd1);
    checkOutput("t1_adr", log_adr[0], 32'h00C00000);
    checkOutput("t1_sel", {28'b0, log_sel[0]}, 32'h1);
    checkOutput("t1_dat", log_dat[0], 32'hA5A5A5A5);
    checkOutput("t1_we", {31'b0, log_we[0]}, 32'd1);
    checkOutput("t1_wr_ptr", wr_ptr, 32'h00C00001);

    // Five bytes walk the byte lanes.
    doReset();
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h44); applyStimulus(8'h55);
    waitCycles(30);
    checkOutput("t2_count", log_adr.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t2_adr%0d", i), log_adr[i], exp_adr[i]);
      checkOutput($sformatf("t2_sel%0d", i), {28'b0, log_sel[i]}, {28'b0, exp_sel[i]});
      checkOutput($sformatf("t2_dat%0d", i), log_dat[i], exp_dat[i]);
    end

    // Window wrap: the ninth byte lands at ADR_LL.
    doReset();
    for (int i = 1; i <= 9; i++) applyStimulus(8'(i));
    waitCycles(40);
    checkOutput("t3_count", log_adr.size(), 32'd9);
    checkOutput("t3_adr7", log_adr[7], 32'h00C00004);
    checkOutput("t3_sel7", {28'b0, log_sel[7]}, 32'h8);
    checkOutput("t3_adr8", log_adr[8], 32'h00C00000);
    checkOutput("t3_sel8", {28'b0, log_sel[8]}, 32'h1);
    checkOutput("t3_dat8", log_dat[8], 32'h09090909);
    checkOutput("t3_wr_ptr", wr_ptr, 32'h00C00001);

    // CPU read held while bytes arrive: grants alternate.
    doReset();
    @(negedge clk); #1
    cpu_cyc = 1'b1; cpu_adr = 32'h00C00100; cpu_we = 1'b0; cpu_sel = 4'hF;
    rx_done = 1'b1; rx_data = 8'h66;
    @(negedge clk); #1 rx_done = 1'b0;
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    n = 0;
    while (log_we.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_grants", {31'b0, log_we.size() >= 6}, 32'd1);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t4_kind%0d", i), {31'b0, log_we[i]}, {31'b0, 1'(i % 2)});
    checkOutput("t4_dma_dat", log_dat[1], 32'h66666666);
    checkOutput("t4_cpu_rdt", last_rdt, 32'h5A9A0100);
    waitCpuAck("t4_final_ack");
    waitCycles(5);

    // Overflow while the CPU holds the port.
    doReset();
    @(negedge clk); #1
    stall = 1'b1; cpu_cyc = 1'b1; cpu_adr = 32'h00C00100; cpu_we = 1'b0; cpu_sel = 4'hF;
    waitCycles(2);
    for (int i = 1; i <= 17; i++) applyStimulus(8'(i));
    checkOutput("t5_overflow", {31'b0, overflow}, 32'd1);
    checkOutput("t5_no_writes", log_adr.size(), 32'd0);
    stall = 1'b0;
    waitCpuAck("t5_cpu_ack");
    waitCycles(60);
    checkOutput("t5_count", log_adr.size(), 32'd17);
    checkOutput("t5_first", log_dat[1], 32'h01010101);
    checkOutput("t5_last", log_dat[16], 32'h10101010);
    checkOutput("t5_wr_ptr", wr_ptr, 32'h00C00000);
    checkOutput("t5_sticky", {31'b0, overflow}, 32'd1);

    // Access to ADR_UL.
    clearLogs();
    @(negedge clk); #1
    cpu_cyc = 1'b1; cpu_adr = UL; cpu_we = 1'b0; cpu_sel = 4'hF;
    waitCpuAck("t6_rd_ack");
`ifdef RX_DMA_STATUS_EN
    checkOutput("t6_status", last_rdt, 32'h80C00000);
    checkOutput("t6_no_ram", {31'b0, ram_cyc_seen}, 32'd0);
    @(negedge clk); #1
    cpu_cyc = 1'b1; cpu_we = 1'b1; cpu_dat = 32'h80000000;
    waitCpuAck("t6_wr_ack");
    waitCycles(2);
    checkOutput("t6_cleared", {31'b0, overflow}, 32'd0);
`else
    checkOutput("t6_ram_adr", log_adr[0], UL);
    checkOutput("t6_rdt", last_rdt, 32'h5A9A0008);
    waitCycles(2);
    checkOutput("t6_sticky", {31'b0, overflow}, 32'd1);
`endif

    // Reset in the middle of a stalled DMA write.
    doReset();
    stall = 1'b1;
    applyStimulus(8'hC3);
    applyStimulus(8'h3C);
    checkOutput("t7_in_dma", {31'b0, ram_cyc}, 32'd1);
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_ram_cyc", {31'b0, ram_cyc}, 32'd0);
    checkOutput("t7_wr_ptr", wr_ptr, LL);
    #1 rst = 1'b0; stall = 1'b0;
    clearLogs();
    waitCycles(10);
    checkOutput("t7_fifo_empty", {31'b0, ram_cyc_seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
